// File: rtl/xcvr_reconfig_mgmt_master_if.sv
// Command/response handshake and Avalon-MM mgmt bus between control logic,
// the reconfig mgmt master and the reconfig controller mgmt slave.
interface xcvr_reconfig_mgmt_master_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic              cmd_poll;
    logic [ADDR_W-1:0] cmd_address;
    logic [DATA_W-1:0] cmd_writedata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_readdata;
    logic              rsp_error;
    logic              busy;
    logic [ADDR_W-1:0] mgmt_address;
    logic              mgmt_read;
    logic              mgmt_write;
    logic [DATA_W-1:0] mgmt_writedata;
    logic [DATA_W-1:0] mgmt_readdata;
    logic              mgmt_waitrequest;

    modport master (
        input  cmd_valid, cmd_write, cmd_poll, cmd_address, cmd_writedata,
        input  mgmt_readdata, mgmt_waitrequest,
        output cmd_ready, rsp_valid, rsp_readdata, rsp_error, busy,
        output mgmt_address, mgmt_read, mgmt_write, mgmt_writedata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_poll, cmd_address, cmd_writedata,
        output mgmt_readdata, mgmt_waitrequest,
        input  cmd_ready, rsp_valid, rsp_readdata, rsp_error, busy,
        input  mgmt_address, mgmt_read, mgmt_write, mgmt_writedata
    );
endinterface

// File: rtl/xcvr_reconfig_mgmt_master.sv
// Single-outstanding Avalon-MM master for the reconfig controller mgmt port.
// Define XCVR_RECONFIG_POLL_EN to enable post-write busy polling (cmd_poll).
module xcvr_reconfig_mgmt_master #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1024,
    parameter int BUSY_BIT    = 8,
    parameter int POLL_GAP    = 16,
    parameter int MAX_POLLS   = 4096
) (
    input logic                      clk_clk,
    input logic                      reset_reset_n,
    xcvr_reconfig_mgmt_master_if.master bus
);
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_POLL_GAP, S_RESP} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              err_q, err_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

`ifdef XCVR_RECONFIG_POLL_EN
    localparam int GAP_W = $clog2(POLL_GAP + 1);
    localparam int PC_W  = $clog2(MAX_POLLS + 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(POLL_GAP - 1);
    localparam logic [PC_W-1:0]  POLL_LAST = PC_W'(MAX_POLLS - 1);

    logic              poll_q, poll_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [PC_W-1:0]   poll_cnt_q, poll_cnt_d;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            poll_q     <= 1'b0;
            gap_cnt_q  <= '0;
            poll_cnt_q <= '0;
        end else begin
            poll_q     <= poll_d;
            gap_cnt_q  <= gap_cnt_d;
            poll_cnt_q <= poll_cnt_d;
        end
    end
`else
    logic unused_poll;
    assign unused_poll = bus.cmd_poll;
`endif

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            err_q    <= err_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        err_d    = err_q;
        to_cnt_d = to_cnt_q;
`ifdef XCVR_RECONFIG_POLL_EN
        poll_d     = poll_q;
        gap_cnt_d  = gap_cnt_q;
        poll_cnt_d = poll_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    addr_d   = bus.cmd_address;
                    wdata_d  = bus.cmd_writedata;
                    rd_d     = !bus.cmd_write;
                    wr_d     = bus.cmd_write;
                    to_cnt_d = '0;
                    state_d  = S_XFER;
`ifdef XCVR_RECONFIG_POLL_EN
                    poll_d     = bus.cmd_write & bus.cmd_poll;
                    poll_cnt_d = '0;
`endif
                end
            end
            S_XFER: begin
                if (!bus.mgmt_waitrequest) begin
                    rd_d     = 1'b0;
                    wr_d     = 1'b0;
                    to_cnt_d = '0;
                    err_d    = 1'b0;
                    rdata_d  = rd_q ? bus.mgmt_readdata : '0;
                    state_d  = S_RESP;
`ifdef XCVR_RECONFIG_POLL_EN
                    if (poll_q && wr_q) begin
                        // Write done: turn straight around into a status read.
                        rd_d    = 1'b1;
                        state_d = S_XFER;
                    end else if (poll_q && bus.mgmt_readdata[BUSY_BIT]) begin
                        if (poll_cnt_q == POLL_LAST) begin
                            err_d   = 1'b1;
                            rdata_d = '0;
                        end else begin
                            poll_cnt_d = poll_cnt_q + PC_W'(1);
                            gap_cnt_d  = '0;
                            state_d    = S_POLL_GAP;
                        end
                    end
`endif
                end else if (to_cnt_q == TO_LAST) begin
                    rd_d     = 1'b0;
                    wr_d     = 1'b0;
                    err_d    = 1'b1;
                    rdata_d  = '0;
                    to_cnt_d = '0;
                    state_d  = S_RESP;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_POLL_GAP: begin
`ifdef XCVR_RECONFIG_POLL_EN
                if (gap_cnt_q == GAP_LAST) begin
                    rd_d     = 1'b1;
                    to_cnt_d = '0;
                    state_d  = S_XFER;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_RESP: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.cmd_ready      = (state_q == S_IDLE);
    assign bus.busy           = (state_q != S_IDLE);
    assign bus.rsp_valid      = (state_q == S_RESP);
    assign bus.rsp_error      = err_q;
    assign bus.rsp_readdata   = rdata_q;
    assign bus.mgmt_address   = addr_q;
    assign bus.mgmt_read      = rd_q;
    assign bus.mgmt_write     = wr_q;
    assign bus.mgmt_writedata = wdata_q;
endmodule

// File: tb/tb_xcvr_reconfig_mgmt_master.sv
// Directed bench for xcvr_reconfig_mgmt_master; poll test only when
// XCVR_RECONFIG_POLL_EN is defined.
module tb_xcvr_reconfig_mgmt_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   xfers = 0, rsps = 0, bad_ovl = 0;

    xcvr_reconfig_mgmt_master_if #(.ADDR_W(7), .DATA_W(32)) bus ();

    xcvr_reconfig_mgmt_master dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mgmt_read && bus.mgmt_write) bad_ovl++;
            if (bus.cmd_ready && bus.busy) bad_ovl++;
            if ((bus.mgmt_read || bus.mgmt_write) && !bus.mgmt_waitrequest) xfers++;
            if (bus.rsp_valid) rsps++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input logic wr, input logic [6:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd, output logic err, output int lat);
        bus.cmd_write = wr; bus.cmd_poll = 1'b0; bus.cmd_address = addr;
        bus.cmd_writedata = wd; bus.cmd_valid = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 3000) begin step(); lat++; end
        if (!bus.rsp_valid) chk("rsp_timeout", 32'(lat), 32'd0);
        rd = bus.rsp_readdata; err = bus.rsp_error;
        step();
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        int          lat, n, x0, r0, idx, seen;
        logic [31:0] rsp_d [3];
        logic        c_wr [3]   = '{1'b1, 1'b0, 1'b1};
        logic [6:0]  c_ad [3]   = '{7'h20, 7'h21, 7'h22};
        logic [31:0] c_wd [3]   = '{32'hA5, 32'h0, 32'h5A};

        bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_poll = 0;
        bus.cmd_address = '0; bus.cmd_writedata = '0;
        bus.mgmt_readdata = '0; bus.mgmt_waitrequest = 1'b0;
        step(); step();
        chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_strobes", {30'd0, bus.mgmt_read, bus.mgmt_write}, 32'd0);
        chk("rst_addr", 32'(bus.mgmt_address), 32'd0);
        chk("rst_wdata", bus.mgmt_writedata, 32'd0);
        chk("rst_rdata", bus.rsp_readdata, 32'd0);
        chk("rst_rsp", {30'd0, bus.rsp_valid, bus.rsp_error}, 32'd0);
        rst_n = 1'b1;
        step();

        // 1: zero-wait read
        bus.cmd_write = 0; bus.cmd_address = 7'h0A; bus.cmd_valid = 1;
        bus.mgmt_readdata = 32'h1234_5678;
        step();
        bus.cmd_valid = 0;
        chk("t1_read_c1", 32'(bus.mgmt_read), 32'd1);
        chk("t1_write_c1", 32'(bus.mgmt_write), 32'd0);
        chk("t1_addr", 32'(bus.mgmt_address), 32'h0A);
        chk("t1_ready_c1", 32'(bus.cmd_ready), 32'd0);
        chk("t1_busy_c1", 32'(bus.busy), 32'd1);
        chk("t1_rsp_c1", 32'(bus.rsp_valid), 32'd0);
        step();
        chk("t1_read_c2", 32'(bus.mgmt_read), 32'd0);
        chk("t1_rsp_c2", 32'(bus.rsp_valid), 32'd1);
        chk("t1_rdata", bus.rsp_readdata, 32'h1234_5678);
        chk("t1_err", 32'(bus.rsp_error), 32'd0);
        chk("t1_busy_c2", 32'(bus.busy), 32'd1);
        step();
        chk("t1_rsp_c3", 32'(bus.rsp_valid), 32'd0);
        chk("t1_ready_c3", 32'(bus.cmd_ready), 32'd1);
        chk("t1_busy_c3", 32'(bus.busy), 32'd0);

        // 2: write stalled 5 cycles by waitrequest
        bus.cmd_write = 1; bus.cmd_address = 7'h0B; bus.cmd_writedata = 32'h3;
        bus.cmd_valid = 1; bus.mgmt_waitrequest = 1;
        step();
        bus.cmd_valid = 0; bus.cmd_address = 7'h7F; bus.cmd_writedata = 32'hFFFF_FFFF;
        for (int i = 0; i < 6; i++) begin
            bus.mgmt_waitrequest = (i == 5) ? 1'b0 : 1'b1;
            chk($sformatf("t2_wr_%0d", i), 32'(bus.mgmt_write), 32'd1);
            chk($sformatf("t2_ad_%0d", i), 32'(bus.mgmt_address), 32'h0B);
            chk($sformatf("t2_wd_%0d", i), bus.mgmt_writedata, 32'h3);
            chk($sformatf("t2_rd_%0d", i), 32'(bus.mgmt_read), 32'd0);
            step();
        end
        chk("t2_wr_end", 32'(bus.mgmt_write), 32'd0);
        chk("t2_rsp", 32'(bus.rsp_valid), 32'd1);
        chk("t2_err", 32'(bus.rsp_error), 32'd0);
        chk("t2_rdata", bus.rsp_readdata, 32'd0);
        step();
        chk("t2_rsp_once", 32'(bus.rsp_valid), 32'd0);

        // 3: read timeout, then a normal read
        bus.cmd_write = 0; bus.cmd_address = 7'h0D; bus.cmd_valid = 1;
        bus.mgmt_waitrequest = 1; bus.mgmt_readdata = 32'hDEAD_BEEF;
        step();
        bus.cmd_valid = 0;
        n = 0;
        while (bus.mgmt_read && n < 2000) begin n++; step(); end
        chk("t3_strobe_cycles", 32'(n), 32'd1024);
        chk("t3_rsp", 32'(bus.rsp_valid), 32'd1);
        chk("t3_err", 32'(bus.rsp_error), 32'd1);
        chk("t3_rdata", bus.rsp_readdata, 32'd0);
        bus.mgmt_waitrequest = 0;
        step();
        chk("t3_ready", 32'(bus.cmd_ready), 32'd1);
        chk("t3_err_clr", 32'(bus.rsp_error), 32'd0);
        bus.mgmt_readdata = 32'hCAFE_F00D;
        run_cmd(1'b0, 7'h11, 32'h0, rd, err, lat);
        chk("t3_next_rdata", rd, 32'hCAFE_F00D);
        chk("t3_next_err", 32'(err), 32'd0);
        chk("t3_next_lat", 32'(lat), 32'd2);

`ifdef XCVR_RECONFIG_POLL_EN
        begin
            int cyc, nrd, nwr;
            int rd_cyc [8];
            bus.cmd_write = 1; bus.cmd_poll = 1; bus.cmd_address = 7'h0C;
            bus.cmd_writedata = 32'h1; bus.cmd_valid = 1;
            step();
            bus.cmd_valid = 0; bus.cmd_poll = 0;
            cyc = 1; nrd = 0; nwr = 0;
            while (!bus.rsp_valid && cyc < 500) begin
                if (bus.mgmt_write) nwr++;
                if (bus.mgmt_read) begin
                    if (nrd < 8) rd_cyc[nrd] = cyc;
                    nrd++;
                    chk($sformatf("t4_addr_%0d", nrd), 32'(bus.mgmt_address), 32'h0C);
                end
                bus.mgmt_readdata = (nrd <= 2) ? 32'h100 : 32'h0;
                step(); cyc++;
            end
            chk("t4_rsp", 32'(bus.rsp_valid), 32'd1);
            chk("t4_writes", 32'(nwr), 32'd1);
            chk("t4_reads", 32'(nrd), 32'd3);
            chk("t4_gap1", 32'(rd_cyc[1] - rd_cyc[0]), 32'd17);
            chk("t4_gap2", 32'(rd_cyc[2] - rd_cyc[1]), 32'd17);
            chk("t4_rdata", bus.rsp_readdata, 32'd0);
            chk("t4_err", 32'(bus.rsp_error), 32'd0);
            step();
        end
`endif

        // 5: reset asserted mid-stall
        bus.cmd_write = 1; bus.cmd_address = 7'h05; bus.cmd_writedata = 32'h77;
        bus.cmd_valid = 1; bus.mgmt_waitrequest = 1;
        step();
        bus.cmd_valid = 0;
        step(); step();
        chk("t5_wr_pre", 32'(bus.mgmt_write), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_strobes", {30'd0, bus.mgmt_read, bus.mgmt_write}, 32'd0);
        chk("t5_busy", 32'(bus.busy), 32'd0);
        chk("t5_rsp", 32'(bus.rsp_valid), 32'd0);
        step();
        rst_n = 1'b1;
        r0 = rsps;
        step(); step();
        chk("t5_ready", 32'(bus.cmd_ready), 32'd1);
        chk("t5_no_rsp", 32'(rsps - r0), 32'd0);
        bus.mgmt_waitrequest = 0;

        // 6: cmd_valid held high across three commands
        x0 = xfers; r0 = rsps; idx = 0; seen = 0;
        bus.mgmt_readdata = 32'h55AA;
        bus.cmd_write = c_wr[0]; bus.cmd_address = c_ad[0]; bus.cmd_writedata = c_wd[0];
        bus.cmd_valid = 1;
        n = 0;
        while (seen < 3 && n < 60) begin
            logic acc;
            acc = bus.cmd_ready & bus.cmd_valid;
            if (bus.rsp_valid) begin rsp_d[seen] = bus.rsp_readdata; seen++; end
            step(); n++;
            if (acc) begin
                idx++;
                if (idx < 3) begin
                    bus.cmd_write = c_wr[idx]; bus.cmd_address = c_ad[idx];
                    bus.cmd_writedata = c_wd[idx];
                end else bus.cmd_valid = 0;
            end
        end
        step();
        chk("t6_xfers", 32'(xfers - x0), 32'd3);
        chk("t6_rsps", 32'(rsps - r0), 32'd3);
        chk("t6_cycles", 32'(n), 32'd9);
        chk("t6_rd0", rsp_d[0], 32'd0);
        chk("t6_rd1", rsp_d[1], 32'h55AA);
        chk("t6_rd2", rsp_d[2], 32'd0);
        chk("no_overlap", 32'(bad_ovl), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
